// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared state type and constants for the bus arbiter.
// Revision: 1.0
`default_nettype none

package bus_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } bus_arb_state_t;

  localparam int             BUS_N_SRC    = 32;
  localparam int             BUS_SEL_W    = 5;
  localparam logic [4:0]     BUS_SEL_IDLE = 5'b11111;

endpackage

`default_nettype wire

// File: rtl/bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker (rotate, priority-find, un-rotate).
// Revision: 1.0
`default_nettype none

module rr_pick
  import bus_arb_pkg::*;
(
  input  logic [BUS_N_SRC-1:0] req,
  input  logic [BUS_SEL_W-1:0] ptr,
  output logic                 any,
  output logic [BUS_SEL_W-1:0] idx,
  output logic [BUS_N_SRC-1:0] win
);

  logic [BUS_N_SRC-1:0] w_rot;
  logic [BUS_SEL_W-1:0] w_ridx;
  logic                 w_found;

  // Bit 0 of the rotated vector is the source at ptr.
  assign w_rot = BUS_N_SRC'({req, req} >> ptr);

  always_comb begin
    w_ridx  = '0;
    w_found = 1'b0;
    for (int i = 0; i < BUS_N_SRC; i++) begin
      if (!w_found && w_rot[i]) begin
        w_ridx  = BUS_SEL_W'(i);
        w_found = 1'b1;
      end
    end
  end

  assign any = |req;
  assign idx = w_ridx + ptr;
  assign win = any ? (BUS_N_SRC'(1) << idx) : '0;

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus arbiter with registered one-hot grant and select.
// Optional forced release compiled in with macro BUS_ARB_TIMEOUT_EN. Revision: 1.0
`default_nettype none

module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N_SRC    = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [N_SRC-1:0]     req,
  input  logic                 done,
  output logic [N_SRC-1:0]     grant,
  output logic [BUS_SEL_W-1:0] sel,
  output logic                 valid,
  output logic                 timeout
);

  bus_arb_state_t       r_state, w_state_nxt;
  logic [N_SRC-1:0]     r_grant, w_grant_nxt;
  logic [BUS_SEL_W-1:0] r_sel, w_sel_nxt;
  logic                 r_valid, w_valid_nxt;
  logic [BUS_SEL_W-1:0] r_ptr, w_ptr_nxt;
  logic                 w_release;
  logic                 w_any;
  logic [BUS_SEL_W-1:0] w_idx;
  logic [N_SRC-1:0]     w_win;

  // MAX_HOLD outside 2..255 is unsupported; this block only marks that range.
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_timeout, w_timeout_nxt;
`endif

  rr_pick u_pick (
    .req (req),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_idx),
    .win (w_win)
  );

  assign w_release = done | ~req[r_sel];

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_sel_nxt   = r_sel;
    w_valid_nxt = r_valid;
    w_ptr_nxt   = r_ptr;
`ifdef BUS_ARB_TIMEOUT_EN
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
`endif
    case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          w_state_nxt = ARB_GRANT;
          w_grant_nxt = w_win;
          w_sel_nxt   = w_idx;
          w_valid_nxt = 1'b1;
          w_ptr_nxt   = w_idx + 5'd1;
`ifdef BUS_ARB_TIMEOUT_EN
          w_cnt_nxt   = '0;
`endif
        end
      end
      ARB_GRANT: begin
        // Normal release wins over a forced release on the same cycle.
        if (w_release) begin
          w_state_nxt = ARB_IDLE;
          w_grant_nxt = '0;
          w_sel_nxt   = BUS_SEL_IDLE;
          w_valid_nxt = 1'b0;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (r_cnt == c_hold_last) begin
          w_state_nxt   = ARB_IDLE;
          w_grant_nxt   = '0;
          w_sel_nxt     = BUS_SEL_IDLE;
          w_valid_nxt   = 1'b0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
`endif
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_sel   <= BUS_SEL_IDLE;
      r_valid <= 1'b0;
      r_ptr   <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
      r_cnt     <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_sel   <= w_sel_nxt;
      r_valid <= w_valid_nxt;
      r_ptr   <= w_ptr_nxt;
`ifdef BUS_ARB_TIMEOUT_EN
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
`endif
    end
  end

  assign grant = r_grant;
  assign sel   = r_sel;
  assign valid = r_valid;
`ifdef BUS_ARB_TIMEOUT_EN
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scoreboard bench for bus_arbiter.
// Revision: 1.0
`default_nettype none

module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] req = '0;
  logic        done = 1'b0;
  logic [31:0] grant;
  logic [4:0]  sel;
  logic        valid;
  logic        timeout;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string tag;
    int    idx;   // -1 means bus idle
    logic  to;
  } exp_t;

  exp_t sb[$];

  bus_arbiter #(.N_SRC(32), .MAX_HOLD(4)) dut (
    .clk     (clk),
    .clr     (clr),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .sel     (sel),
    .valid   (valid),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, push the expected post-edge outputs, then compare.
  task automatic cyc(input logic c, input logic [31:0] r, input logic d,
                     input string tag, input int idx, input logic to);
    exp_t e;
    logic [31:0] eg;
    logic [4:0]  es;
    clr  = c;
    req  = r;
    done = d;
    e.tag = tag;
    e.idx = idx;
    e.to  = to;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e  = sb.pop_front();
    eg = (e.idx < 0) ? 32'd0 : (32'd1 << e.idx);
    es = (e.idx < 0) ? 5'b11111 : 5'(e.idx);
    chk({e.tag, ".grant"},   grant,          eg);
    chk({e.tag, ".sel"},     {27'd0, sel},   {27'd0, es});
    chk({e.tag, ".valid"},   {31'd0, valid}, {31'd0, (e.idx >= 0)});
    chk({e.tag, ".timeout"}, {31'd0, timeout}, {31'd0, e.to});
  endtask

  initial begin
    // Reset with all requests pending, then first grant goes to source 0.
    cyc(1, 32'hFFFF_FFFF, 0, "rst0", -1, 0);
    cyc(1, 32'hFFFF_FFFF, 0, "rst1", -1, 0);
    cyc(0, 32'hFFFF_FFFF, 0, "first", 0, 0);
    cyc(0, 32'h0000_0000, 0, "first_rel", -1, 0);

    // Round robin over sources 0, 2, 8, 0 starting from ptr 0.
    cyc(1, 32'h0, 0, "rr_rst", -1, 0);
    cyc(0, 32'h0000_0105, 0, "rr_g0", 0, 0);
    cyc(0, 32'h0000_0105, 0, "rr_h0", 0, 0);
    cyc(0, 32'h0000_0105, 1, "rr_r0", -1, 0);
    cyc(0, 32'h0000_0105, 0, "rr_g2", 2, 0);
    cyc(0, 32'h0000_0105, 0, "rr_h2", 2, 0);
    cyc(0, 32'h0000_0105, 1, "rr_r2", -1, 0);
    cyc(0, 32'h0000_0105, 0, "rr_g8", 8, 0);
    cyc(0, 32'h0000_0105, 0, "rr_h8", 8, 0);
    cyc(0, 32'h0000_0105, 1, "rr_r8", -1, 0);
    cyc(0, 32'h0000_0105, 0, "rr_g0b", 0, 0);
    cyc(0, 32'h0000_0105, 0, "rr_h0b", 0, 0);
    cyc(0, 32'h0000_0000, 1, "rr_r0b", -1, 0);

    // Walk ptr to 31 via source 30, released by dropping its request.
    cyc(0, 32'h4000_0000, 0, "g30", 30, 0);
    cyc(0, 32'h0000_0000, 0, "drop30", -1, 0);
    cyc(0, 32'h8000_0001, 0, "wrap_g31", 31, 0);
    cyc(0, 32'h8000_0001, 1, "wrap_r31", -1, 0);
    cyc(0, 32'h8000_0001, 0, "wrap_g0", 0, 0);
    cyc(0, 32'h0000_0000, 1, "wrap_r0", -1, 0);

    // Owner 5 drop; non-owner requests ignored while granted.
    cyc(0, 32'h0000_0020, 0, "g5", 5, 0);
    cyc(0, 32'h0000_0021, 0, "g5_other", 5, 0);
    cyc(0, 32'h0000_0000, 0, "drop5", -1, 0);
    // done and request drop together: a single release.
    cyc(0, 32'h0000_0020, 0, "g5b", 5, 0);
    cyc(0, 32'h0000_0000, 1, "both_rel", -1, 0);
    cyc(0, 32'h0000_0000, 0, "both_idle", -1, 0);
    // done in IDLE has no effect.
    cyc(0, 32'h0000_0000, 1, "idle_done", -1, 0);
    cyc(0, 32'h0000_0020, 1, "idle_done_req", 5, 0);
    cyc(0, 32'h0000_0020, 0, "idle_done_hold", 5, 0);
    cyc(0, 32'h0000_0000, 0, "idle_done_rel", -1, 0);

    // Reset mid-grant of source 12; ptr back to 0 so 12 beats 14.
    cyc(0, 32'h0000_1000, 0, "g12", 12, 0);
    cyc(0, 32'h0000_1000, 0, "h12", 12, 0);
    cyc(1, 32'h0000_1000, 0, "clr12", -1, 0);
    cyc(0, 32'h0000_5000, 0, "ptr0_g12", 12, 0);
    cyc(0, 32'h0000_5000, 1, "ptr0_r12", -1, 0);

    // Source 3 holds without done.
    cyc(0, 32'h0000_0008, 0, "hold_g3", 3, 0);
`ifdef BUS_ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) cyc(0, 32'h0000_0008, 0, "hold3", 3, 0);
    cyc(0, 32'h0000_0008, 0, "to_rel", -1, 1);
    cyc(0, 32'h0000_0008, 0, "to_regrant", 3, 0);
    for (int i = 0; i < 3; i++) cyc(0, 32'h0000_0008, 0, "hold3b", 3, 0);
    cyc(0, 32'h0000_0008, 1, "to_done_wins", -1, 0);
`else
    for (int i = 0; i < 8; i++) cyc(0, 32'h0000_0008, 0, "hold3", 3, 0);
    cyc(0, 32'h0000_0008, 1, "hold3_rel", -1, 0);
`endif
    cyc(0, 32'h0000_0000, 0, "end_idle", -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter and sequencer for the shared 32-source CPU bus. Accepts per-source bus requests, grants the bus to exactly one source at a time, and drives the registered one-hot grant and 5-bit select that feed the bus multiplexer. The select output uses the same source index encoding the bus encoder produces, so the two are interchangeable at the mux select input. Sits between the control unit's register-out strobes and the bus mux.

## Interface

**Parameters**
- `N_SRC`, 32: number of bus sources; fixed at 32 in this revision.
- `MAX_HOLD`, 16: maximum consecutive cycles one owner may hold the bus. Used only with the timeout feature; legal range is 2..255.

**Ports**
- `clk`, in, 1: sole clock; all state updates on the rising edge.
- `clr`, in, 1: synchronous, active-high reset.
- `req`, in, 32: per-source request, level-sensitive.
- `done`, in, 1: current owner releases the bus. Single-cycle pulse, sampled only in GRANT.
- `grant`, out, 32: registered one-hot grant; all zeros when the bus is idle.
- `sel`, out, 5: binary index of the granted source; `5'b11111` when idle.
- `valid`, out, 1: high while a grant is active.
- `timeout`, out, 1: one-cycle pulse when an owner is forcibly released. Constant 0 unless the timeout feature is compiled in.

## Operation

**State machine:** IDLE and GRANT.

**Reset (`clr`=1 at the edge)**
- State returns to IDLE.
- `grant`=0, `sel`=5'b11111, `valid`=0, `timeout`=0.
- Priority pointer `ptr`=0; hold counter=0.
- Reset overrides all other inputs, including during an active grant. The grant drops at that edge.

**IDLE**
- If `req`≠0, pick the first set bit scanning upward from `ptr`, wrapping from 31 to 0.
- Register the winner `w` at that edge: `grant`=1<<`w`, `sel`=`w`, `valid`=1.
- Set `ptr`=(`w`+1) mod 32, so winner 31 sets `ptr` to 0.
- Go to GRANT.
- If `req`=0, stay in IDLE with outputs at their idle values.

**GRANT**
- Outputs hold steady.
- Release when `done`=1 or `req[sel]`=0. On release, outputs return to idle values at that edge and the state goes to IDLE.
- Release always passes through one IDLE cycle, which is the mandatory bus turnaround. Back-to-back grants are therefore at least 2 cycles apart.
- Requests from non-owners are ignored while in GRANT. They are considered at the next IDLE cycle.
- `done` together with `req[sel]` dropping in the same cycle counts as a single release.
- `done` asserted while in IDLE is ignored.

**Fairness**
- Any continuously asserted request is granted within 32 arbitration rounds.

## Timing

- Request-to-grant latency is 1 cycle: a request seen in IDLE at edge k produces a grant visible after edge k.
- Release-to-idle latency is 1 cycle. The earliest next grant comes 1 cycle after that.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Configuration

**`BUS_ARB_TIMEOUT_EN` defined**
- An 8-bit hold counter clears on entry to GRANT and increments each cycle spent in GRANT.
- When the counter equals `MAX_HOLD`−1 and no normal release occurs, the owner is forcibly released at that edge and `timeout` pulses high for the following cycle.
- The owner therefore holds the bus for at most `MAX_HOLD` cycles.
- A normal release on the same cycle takes precedence, and no `timeout` pulse is produced.

**`BUS_ARB_TIMEOUT_EN` undefined**
- No counter is built. `timeout` is tied to 0 and the hold time is unbounded.

## Structure

- Package `bus_arb_pkg` contains:
  - state enum `bus_arb_state_t` {ARB_IDLE, ARB_GRANT};
  - constants `BUS_N_SRC`=32, `BUS_SEL_W`=5, `BUS_SEL_IDLE`=5'b11111.
- Sub-module `rr_pick`: a combinational round-robin picker. Inputs are `req[31:0]` and `ptr[4:0]`; outputs are `any`, `idx[4:0]` and a one-hot `win[31:0]`. Implementation is rotate, priority-find, un-rotate.
- Top level holds the FSM, `ptr`, the output registers and the optional counter.

## Test plan

- Reset: `clr` high for 2 cycles with `req`=32'hFFFFFFFF gives `grant`=0, `sel`=5'b11111, `valid`=0. After `clr` falls, the first grant goes to source 0.
- Round robin: `req`=32'h0000_0105 held, each owner pulsing `done` 2 cycles after its grant. Grant order must be 0, 2, 8, 0, with exactly one idle cycle between grants.
- Wrap-around: `ptr` at 31 with `req`=32'h8000_0001. Grant goes to 31, then after release to 0. `sel` reads 5'b11111 only on the idle cycles.
- Request drop and simultaneous events:
  - Owner 5 drops `req[5]` → idle the next cycle.
  - `done` plus request drop in the same cycle → a single release.
  - `done` pulsed in IDLE → no effect.
- Reset mid-grant: `clr` asserted while source 12 owns the bus → outputs return to idle values at that edge and `ptr` returns to 0.
- Timeout (macro defined, `MAX_HOLD`=4): source 3 holds its request with no `done` → grant lasts exactly 4 cycles, then `timeout`=1 for 1 cycle. With the macro undefined, the same stimulus holds the grant indefinitely and `timeout` stays 0.
